draw_arbiter: RTL and testbench

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_arbiter_if.sv | 29 ++
 rtl/draw_arbiter.sv | 100 ++++++++++
 tb/tb_draw_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/draw_arbiter_if.sv
// Bundle between the requesters, the draw arbiter and the rectangle engine.
// The arbiter uses the slave modport and the requester/engine side uses master.
interface draw_arbiter_if;
  logic [2:0]  req;
  logic [23:0] req_x0;
  logic [23:0] req_y0;
  logic [23:0] req_x1;
  logic [23:0] req_y1;
  logic [2:0]  gnt;
  logic [2:0]  req_done;
  logic        eng_start;
  logic [7:0]  eng_x0;
  logic [7:0]  eng_y0;
  logic [7:0]  eng_x1;
  logic [7:0]  eng_y1;
  logic        eng_done;
  logic        busy;
  logic [1:0]  owner;

  modport master (
    output req, req_x0, req_y0, req_x1, req_y1, eng_done,
    input  gnt, req_done, eng_start, eng_x0, eng_y0, eng_x1, eng_y1, busy, owner
  );

  modport slave (
    input  req, req_x0, req_y0, req_x1, req_y1, eng_done,
    output gnt, req_done, eng_start, eng_x0, eng_y0, eng_x1, eng_y1, busy, owner
  );
endinterface

// File: rtl/draw_arbiter.sv
// Three-way arbiter that hands one rectangle engine to a requester at a time.
// Round-robin by default; defining DRAW_ARB_FIXED_PRIO_EN gives strict priority 0>1>2.
module draw_arbiter (
  input  logic          clk,
  input  logic          rst,
  draw_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [3:0] req_ext;
  logic       win_valid;
  logic [1:0] win_idx;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [23:0] v, input logic [1:0] i);
    case (i)
      2'd1:    return v[15:8];
      2'd2:    return v[23:16];
      default: return v[7:0];
    endcase
  endfunction

  // Search order starts at the pointer; with the pointer pinned at 0 this is strict priority.
  assign cand0   = ptr;
  assign cand1   = next_idx(ptr);
  assign cand2   = next_idx(cand1);
  assign req_ext = {1'b0, bus.req};

  always_comb begin
    win_valid = |bus.req;
    win_idx   = cand2;
    if (req_ext[cand0])
      win_idx = cand0;
    else if (req_ext[cand1])
      win_idx = cand1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 2'd0;
      bus.gnt      <= 3'b000;
      bus.req_done <= 3'b000;
      bus.eng_start <= 1'b0;
      bus.eng_x0   <= 8'd0;
      bus.eng_y0   <= 8'd0;
      bus.eng_x1   <= 8'd0;
      bus.eng_y1   <= 8'd0;
      bus.busy     <= 1'b0;
      bus.owner    <= 2'd0;
    end else begin
      bus.gnt       <= 3'b000;
      bus.req_done  <= 3'b000;
      bus.eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            bus.gnt    <= 3'b001 << win_idx;
            bus.eng_x0 <= pick_byte(bus.req_x0, win_idx);
            bus.eng_y0 <= pick_byte(bus.req_y0, win_idx);
            bus.eng_x1 <= pick_byte(bus.req_x1, win_idx);
            bus.eng_y1 <= pick_byte(bus.req_y1, win_idx);
            bus.owner  <= win_idx;
            bus.busy   <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          bus.eng_start <= 1'b1;
          state         <= WAIT;
        end
        WAIT: begin
          // Coordinates are deliberately left in place after release.
          if (bus.eng_done) begin
            bus.req_done <= 3'b001 << bus.owner;
            bus.busy     <= 1'b0;
            bus.owner    <= 2'd0;
`ifdef DRAW_ARB_FIXED_PRIO_EN
            ptr          <= 2'd0;
`else
            ptr          <= next_idx(bus.owner);
`endif
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed self-checking bench for draw_arbiter; expectations are hand-computed per step.
module tb_draw_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  draw_arbiter_if bus();

  draw_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] rq, input logic done);
    rst          = r;
    bus.req      = rq;
    bus.eng_done = done;
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected winner sequence with all three requesting continuously.
`ifdef DRAW_ARB_FIXED_PRIO_EN
  logic [2:0] rrOrder [4] = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
  logic [2:0] rrOrder [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    bus.req_x0 = {8'd12, 8'd11, 8'd10};
    bus.req_y0 = {8'd22, 8'd21, 8'd20};
    bus.req_x1 = {8'd32, 8'd31, 8'd30};
    bus.req_y1 = {8'd42, 8'd41, 8'd40};
    applyStimulus(1'b1, 3'b000, 1'b0);
    tick();
    tick();
    checkOutput("rst_gnt", 24'(bus.gnt), 24'd0);
    checkOutput("rst_busy", 24'(bus.busy), 24'd0);
    checkOutput("rst_owner", 24'(bus.owner), 24'd0);
    checkOutput("rst_start", 24'(bus.eng_start), 24'd0);
    checkOutput("rst_x0", 24'(bus.eng_x0), 24'd0);

    // Single request from requester 0
    applyStimulus(1'b0, 3'b001, 1'b0);
    tick();
    checkOutput("single_gnt", 24'(bus.gnt), 24'h1);
    checkOutput("single_busy", 24'(bus.busy), 24'h1);
    checkOutput("single_start_early", 24'(bus.eng_start), 24'h0);
    checkOutput("single_coords", {bus.eng_y1, bus.eng_x1, bus.eng_y0}, {8'd40, 8'd30, 8'd20});
    checkOutput("single_x0", 24'(bus.eng_x0), 24'd10);
    applyStimulus(1'b0, 3'b000, 1'b0);
    tick();
    checkOutput("single_start", 24'(bus.eng_start), 24'h1);
    checkOutput("single_gnt_clear", 24'(bus.gnt), 24'h0);
    tick();
    checkOutput("single_start_once", 24'(bus.eng_start), 24'h0);
    applyStimulus(1'b0, 3'b000, 1'b1);
    tick();
    checkOutput("single_done", 24'(bus.req_done), 24'h1);
    checkOutput("single_busy_off", 24'(bus.busy), 24'h0);
    applyStimulus(1'b0, 3'b000, 1'b0);
    tick();
    checkOutput("single_done_once", 24'(bus.req_done), 24'h0);

    // Reset so the pointer starts at 0 for the rotation sequence
    applyStimulus(1'b1, 3'b000, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b111, 1'b0);
    for (int g = 0; g < 4; g++) begin
      tick();
      checkOutput($sformatf("rr_gnt%0d", g), 24'(bus.gnt), 24'(rrOrder[g]));
      if (g == 3) bus.req = 3'b000;
      tick();
      checkOutput($sformatf("rr_start%0d", g), 24'(bus.eng_start), 24'h1);
      for (int w = 0; w < 5; w++) tick();
      checkOutput($sformatf("rr_hold%0d", g), 24'(bus.gnt), 24'h0);
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      checkOutput($sformatf("rr_done%0d", g), 24'(bus.req_done), 24'(rrOrder[g]));
    end

    // Coordinate stability while the owner's inputs change
    applyStimulus(1'b0, 3'b010, 1'b0);
    tick();
    checkOutput("stab_gnt", 24'(bus.gnt), 24'h2);
    checkOutput("stab_x0_cap", 24'(bus.eng_x0), 24'd11);
    applyStimulus(1'b0, 3'b000, 1'b0);
    tick();
    bus.req_x0 = {8'd12, 8'hFF, 8'd10};
    tick();
    tick();
    checkOutput("stab_x0_wait", 24'(bus.eng_x0), 24'd11);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    checkOutput("stab_done", 24'(bus.req_done), 24'h2);
    checkOutput("stab_x0_release", 24'(bus.eng_x0), 24'd11);
    bus.req_x0 = {8'd12, 8'd11, 8'd10};

    // Spurious done while idle, then done during LAUNCH
    applyStimulus(1'b0, 3'b000, 1'b1);
    tick();
    checkOutput("spur_idle_done", 24'(bus.req_done), 24'h0);
    checkOutput("spur_idle_busy", 24'(bus.busy), 24'h0);
    applyStimulus(1'b0, 3'b001, 1'b0);
    tick();
    checkOutput("spur_gnt", 24'(bus.gnt), 24'h1);
    applyStimulus(1'b0, 3'b000, 1'b1);
    tick();
    checkOutput("spur_launch_start", 24'(bus.eng_start), 24'h1);
    checkOutput("spur_launch_done", 24'(bus.req_done), 24'h0);
    applyStimulus(1'b0, 3'b000, 1'b0);
    tick();
    checkOutput("spur_wait_busy", 24'(bus.busy), 24'h1);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    checkOutput("spur_real_done", 24'(bus.req_done), 24'h1);

    // Request from 1 that drops during another owner's draw is discarded
    applyStimulus(1'b0, 3'b001, 1'b0);
    tick();
    checkOutput("drop_owner_gnt", 24'(bus.gnt), 24'h1);
    applyStimulus(1'b0, 3'b000, 1'b0);
    tick();
    tick();
    bus.req = 3'b010;
    tick();
    bus.req = 3'b000;
    checkOutput("drop_gnt_wait", 24'(bus.gnt), 24'h0);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    checkOutput("drop_done", 24'(bus.req_done), 24'h1);
    tick();
    tick();
    checkOutput("drop_gnt_idle", 24'(bus.gnt), 24'h0);
    checkOutput("drop_busy_idle", 24'(bus.busy), 24'h0);

    // Reset in the middle of requester 2's draw
    applyStimulus(1'b0, 3'b100, 1'b0);
    tick();
    checkOutput("rstmid_gnt", 24'(bus.gnt), 24'h4);
    checkOutput("rstmid_owner", 24'(bus.owner), 24'd2);
    applyStimulus(1'b0, 3'b000, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 3'b000, 1'b0);
    tick();
    checkOutput("rstmid_owner0", 24'(bus.owner), 24'd0);
    checkOutput("rstmid_busy0", 24'(bus.busy), 24'd0);
    checkOutput("rstmid_coords0", {bus.eng_x0, bus.eng_y0, bus.eng_y1}, 24'd0);
    checkOutput("rstmid_done0", 24'(bus.req_done), 24'h0);
    applyStimulus(1'b0, 3'b000, 1'b1);
    tick();
    checkOutput("rstmid_no_done", 24'(bus.req_done), 24'h0);
    applyStimulus(1'b0, 3'b101, 1'b0);
    tick();
    checkOutput("rstmid_ptr0_gnt", 24'(bus.gnt), 24'h1);
    applyStimulus(1'b0, 3'b100, 1'b0);
    tick();
    tick();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    checkOutput("rstmid_last_done", 24'(bus.req_done), 24'h1);
    tick();
    checkOutput("rstmid_req100_gnt", 24'(bus.gnt), 24'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
